// File: rtl/alu_pkg.sv
// Shared definitions for the ALU multiply path.
// Data width, latency counter width and sequencer state encoding.
package alu_pkg;

    localparam int DATA_W    = 16;
    localparam int LAT_CNT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        DONE = ST_DONE
    } seq_state_t;

endpackage

// File: rtl/start_edge_detect.sv
// Registers the start request and flags its rising edge.
// Ports: clk, rst (async active-low), start in, rise out (combinational).
module start_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic rise
);

    logic start_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start;
        end
    end

    // start_q clears in reset, so a start held across release reads as a rise
    assign rise = start & ~start_q;

endmodule

// File: rtl/mul_sequencer.sv
// Control stage for the registered multiplier: latches operands on a start
// rise, waits MUL_LAT cycles, captures the product and holds it with finish.
// Ports: clk, rst (async active-low), start, a_in, b_in, mul_out in;
//        mul_a, mul_b, out, busy, finish, start_err out (all registered).
module mul_sequencer
    import alu_pkg::*;
#(
    parameter int N       = DATA_W,
    parameter int MUL_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic [N-1:0] mul_a,
    output logic [N-1:0] mul_b,
    input  logic [N-1:0] mul_out,
    output logic [N-1:0] out,
    output logic         busy,
    output logic         finish,
    output logic         start_err
);

    seq_state_t           state;
    logic [LAT_CNT_W-1:0] cnt;
    logic                 rise;

    start_edge_detect u_edge (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .rise  (rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            out       <= '0;
            busy      <= 1'b0;
            finish    <= 1'b0;
            start_err <= 1'b0;
        end else begin
            start_err <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (rise) begin
                        if (a_in == '0 || b_in == '0) begin
                            // product is known to be zero; skip the multiplier
                            out    <= '0;
                            finish <= 1'b1;
                            state  <= DONE;
                        end else begin
                            mul_a  <= a_in;
                            mul_b  <= b_in;
                            busy   <= 1'b1;
                            finish <= 1'b0;
                            cnt    <= LAT_CNT_W'(MUL_LAT);
                            state  <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (rise) begin
                        start_err <= 1'b1;
                    end
                    if (cnt == '0) begin
                        out    <= mul_out;
                        finish <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Testbench for mul_sequencer with a one-cycle registered multiplier model.
// Expected products are queued at request time and popped on finish.
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [15:0] mul_out;
    logic [15:0] out;
    logic        busy;
    logic        finish;
    logic        start_err;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_a = 16'd0;
    logic [15:0] last_b = 16'd0;

    always #5 clk = ~clk;

    mul_sequencer #(.N(16), .MUL_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_out   (mul_out),
        .out       (out),
        .busy      (busy),
        .finish    (finish),
        .start_err (start_err)
    );

    // stand-in for the registered multiplier, latency 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mul_out <= 16'd0;
        else      mul_out <= 16'(mul_a * mul_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        a_in  = 16'd0;
        b_in  = 16'd0;
        tick();
        tick();
        checks++;
        if ({out, mul_a, mul_b} !== 48'd0) begin
            failures++;
            $display("FAIL reset_data out=%0d mul_a=%0d mul_b=%0d want 0",
                     out, mul_a, mul_b);
        end
        checks++;
        if ({busy, finish, start_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags busy=%b finish=%b err=%b want 000",
                     busy, finish, start_err);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_mul(input logic [15:0] a, input logic [15:0] b,
                            input string name);
        int n;
        logic [15:0] e;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        exp_q.push_back(16'(a * b));
        tick();
        start = 1'b0;
        last_a = a;
        last_b = b;
        checks++;
        if (busy !== 1'b1 || finish !== 1'b0 || mul_a !== a || mul_b !== b) begin
            failures++;
            $display("FAIL %s_accept busy=%b finish=%b mul_a=%0d mul_b=%0d want 1 0 %0d %0d",
                     name, busy, finish, mul_a, mul_b, a, b);
        end
        n = 0;
        while (finish !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL %s_latency cycles=%0d want 2", name, n);
        end
        e = exp_q.pop_front();
        checks++;
        if (out !== e || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_result out=%0d busy=%b want %0d 0", name, out, busy, e);
        end
    endtask

    task automatic test_basic();
        test_mul(16'd2, 16'd3, "basic");
    endtask

    task automatic test_truncate();
        test_mul(16'd258, 16'd258, "trunc258");
        test_mul(16'd32767, 16'd2, "trunc32767");
        for (int i = 0; i < 3; i++) begin
            test_mul(16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535)), "rand");
        end
    endtask

    task automatic test_zero();
        int busy_seen;
        start = 1'b1;
        a_in  = 16'd0;
        b_in  = 16'd123;
        tick();
        start = 1'b0;
        checks++;
        if (finish !== 1'b1 || out !== 16'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_result finish=%b out=%0d busy=%b want 1 0 0",
                     finish, out, busy);
        end
        checks++;
        if (mul_a !== last_a || mul_b !== last_b) begin
            failures++;
            $display("FAIL zero_operands mul_a=%0d mul_b=%0d want %0d %0d",
                     mul_a, mul_b, last_a, last_b);
        end
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy === 1'b1) busy_seen++;
        end
        checks++;
        if (busy_seen != 0 || finish !== 1'b1) begin
            failures++;
            $display("FAIL zero_hold busy_cycles=%0d finish=%b want 0 1",
                     busy_seen, finish);
        end
    endtask

    task automatic test_start_err();
        logic [15:0] e;
        start = 1'b1;
        a_in  = 16'd5;
        b_in  = 16'd4;
        exp_q.push_back(16'd20);
        tick();
        start = 1'b0;
        a_in  = 16'd9;
        b_in  = 16'd9;
        tick();
        checks++;
        if (start_err !== 1'b0) begin
            failures++;
            $display("FAIL err_early start_err=%b want 0", start_err);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (start_err !== 1'b1 || finish !== 1'b1 || out !== e) begin
            failures++;
            $display("FAIL err_pulse start_err=%b finish=%b out=%0d want 1 1 %0d",
                     start_err, finish, out, e);
        end
        tick();
        checks++;
        if (start_err !== 1'b0) begin
            failures++;
            $display("FAIL err_width start_err=%b want 0", start_err);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (out !== 16'd20 || finish !== 1'b1 || busy !== 1'b0 || mul_a !== 16'd5) begin
            failures++;
            $display("FAIL err_dropped out=%0d finish=%b busy=%b mul_a=%0d want 20 1 0 5",
                     out, finish, busy, mul_a);
        end
        last_a = 16'd5;
        last_b = 16'd4;
    endtask

    task automatic test_hold();
        int busy_cnt;
        int fin_rise;
        logic fin_prev;
        start = 1'b1;
        a_in  = 16'd7;
        b_in  = 16'd6;
        busy_cnt = 0;
        fin_rise = 0;
        fin_prev = finish;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
            if (finish === 1'b1 && fin_prev !== 1'b1) fin_rise++;
            fin_prev = finish;
        end
        checks++;
        if (busy_cnt != 2 || fin_rise != 1) begin
            failures++;
            $display("FAIL hold_once busy_cycles=%0d finish_rises=%0d want 2 1",
                     busy_cnt, fin_rise);
        end
        checks++;
        if (out !== 16'd42 || finish !== 1'b1) begin
            failures++;
            $display("FAIL hold_result out=%0d finish=%b want 42 1", out, finish);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        start = 1'b1;
        a_in  = 16'd10;
        b_in  = 16'd10;
        tick();
        start = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (out !== 16'd0 || finish !== 1'b0 || busy !== 1'b0 || mul_a !== 16'd0) begin
            failures++;
            $display("FAIL abort_clear out=%0d finish=%b busy=%b mul_a=%0d want 0 0 0 0",
                     out, finish, busy, mul_a);
        end
        tick();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (finish !== 1'b0 || busy !== 1'b0 || out !== 16'd0) begin
            failures++;
            $display("FAIL abort_idle finish=%b busy=%b out=%0d want 0 0 0",
                     finish, busy, out);
        end
        test_mul(16'd50, 16'd20, "after_abort");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_truncate();
        test_zero();
        test_start_err();
        test_hold();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
